alu_pipelined: RTL

- Next-generation ALU for the microprocessor datapath.
- Parametrised width, 3-bit opcode with eight operations, and a 2-stage registered pipeline.
- Valid/ready handshakes on input and output, with backpressure.
- Sits between the register-file read stage and write-back; flags travel with each result, plus a sticky overflow status bit.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 89 ++++++++
 rtl/alu_pipelined.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and the flag bundle
// that travels with each result.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic sign;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus zero/carry/sign/overflow flags.
// Build option ALU_SAT_EN: ADD/SUB saturate on signed overflow.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_e          op_i,
    output logic [WIDTH-1:0] result_o,
    output alu_flags_t       flags_o
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH:0]   shl_s;
    logic [WIDTH:0]   shr_s;
    logic [SHW-1:0]   shamt_s;
    logic [WIDTH-1:0] raw_s;
    logic [WIDTH-1:0] final_s;
    logic             carry_s;
    logic             ovf_s;

    // The extra bit on each side of the shifters catches the last bit shifted out.
    assign shamt_s = b_i[SHW-1:0];
    assign sum_s   = {1'b0, a_i} + {1'b0, b_i};
    assign diff_s  = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
    assign shl_s   = {1'b0, a_i} << shamt_s;
    assign shr_s   = {a_i, 1'b0} >> shamt_s;

    // Raw result, carry and overflow selection by opcode.
    always_comb begin
        raw_s   = '0;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (op_i)
            OP_ADD: begin
                raw_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                ovf_s   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                raw_s   = diff_s[WIDTH-1:0];
                carry_s = diff_s[WIDTH];
                ovf_s   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  raw_s = a_i & b_i;
            OP_OR:   raw_s = a_i | b_i;
            OP_XOR:  raw_s = a_i ^ b_i;
            OP_SLT:  raw_s = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SHL: begin
                raw_s   = shl_s[WIDTH-1:0];
                carry_s = shl_s[WIDTH];
            end
            OP_SHR: begin
                raw_s   = shr_s[WIDTH:1];
                carry_s = shr_s[0];
            end
            default: begin
                raw_s   = '0;
                carry_s = 1'b0;
                ovf_s   = 1'b0;
            end
        endcase
    end

    // Final result: overflow is only ever raised by ADD/SUB, so it alone gates saturation.
    always_comb begin
`ifdef ALU_SAT_EN
        if (ovf_s) begin
            final_s = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            final_s = raw_s;
        end
`else
        final_s = raw_s;
`endif
    end

    assign result_o          = final_s;
    assign flags_o.zero      = (final_s == {WIDTH{1'b0}});
    assign flags_o.carry     = carry_s;
    assign flags_o.sign      = final_s[WIDTH-1];
    assign flags_o.overflow  = ovf_s;

endmodule

// File: rtl/alu_pipelined.sv
// Two-stage valid/ready ALU pipeline (operand register -> result register) with
// sticky overflow status. Saturating arithmetic when built with ALU_SAT_EN.
module alu_pipelined
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [2:0]       ALU_Control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             sign_flag,
    output logic             overflow_flag,
    input  logic             clr_sticky,
    output logic             sticky_ovf
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    alu_op_e          op_q, op_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    alu_flags_t       flags_q, flags_d;
    logic             sticky_q, sticky_d;

    logic             in_fire_s, s2_load_s, out_fire_s;
    logic [WIDTH-1:0] core_res_s;
    alu_flags_t       core_flags_s;

    assign in_ready   = !s1_valid_q || !out_valid_q || out_ready;
    assign in_fire_s  = in_valid && in_ready;
    assign s2_load_s  = s1_valid_q && (!out_valid_q || out_ready);
    assign out_fire_s = out_valid_q && out_ready;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (core_res_s),
        .flags_o  (core_flags_s)
    );

    // Stage 1 next state: capture on input handshake, empty when stage 2 drains it.
    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        if (in_fire_s) begin
            s1_valid_d = 1'b1;
            a_d        = src_a;
            b_d        = src_b;
            op_d       = alu_op_e'(ALU_Control);
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 next state: load a new result or retire the current one.
    always_comb begin
        out_valid_d = out_valid_q;
        res_d       = res_q;
        flags_d     = flags_q;
        if (s2_load_s) begin
            out_valid_d = 1'b1;
            res_d       = core_res_s;
            flags_d     = core_flags_s;
        end else if (out_fire_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Sticky overflow: a delivered overflow beats a same-cycle clear.
    always_comb begin
        if (out_fire_s && flags_q.overflow) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Pipeline and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            sticky_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign ALU_out       = res_q;
    assign zero_flag     = flags_q.zero;
    assign carry_flag    = flags_q.carry;
    assign sign_flag     = flags_q.sign;
    assign overflow_flag = flags_q.overflow;
    assign sticky_ovf    = sticky_q;

endmodule
